perf_counter_bank: RTL and testbench

Synthesizable, parametrised event-counter bank that replaces bench-only instruction and cache-hit counting with on-chip performance counters. It sits beside the processor core and counts cycles plus `NUM_EVENTS` single-bit event strobes (retired instruction, I/D-cache request, I/D-cache hit, …). It freezes all counts when the processor halts. A registered select/read port exposes any counter and its overflow flag to a debug or memory-mapped reader.

---
 rtl/perf_pkg.sv | 19 +
 rtl/perf_counter.sv | 40 ++++
 rtl/perf_counter_bank.sv | 100 ++++++++++
 tb/tb_perf_counter_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank: event channel indices
// and the bank's run/freeze state encoding.
package perf_pkg;

   // Conventional assignment of event strobes to evt[] bit positions
   localparam int EV_INST = 0;
   localparam int EV_IREQ = 1;
   localparam int EV_IHIT = 2;
   localparam int EV_DREQ = 3;
   localparam int EV_DHIT = 4;

   localparam int MAX_EVENTS = 15;

   typedef enum logic {
      RUN    = 1'b0,
      FROZEN = 1'b1
   } perf_state_t;

endpackage

// File: rtl/perf_counter.sv
// One performance counter with a sticky overflow flag; saturates or wraps
// on the increment that finds it at all-ones.
module perf_counter
   import perf_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             w_at_max;

   assign w_at_max = &r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (inc) begin
         if (w_at_max) begin
            r_ovf <= 1'b1;
            r_cnt <= SATURATE ? r_cnt : '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign cnt = r_cnt;
   assign ovf = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus NUM_EVENTS event counters, frozen on processor halt,
// with a one-cycle registered read port for debug or bus access.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter  int NUM_EVENTS = 5,
   parameter  int CNT_W      = 32,
   parameter  bit SATURATE   = 1'b1,
   localparam int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [NUM_EVENTS-1:0] evt,
   input  logic                  halt,
   input  logic [SEL_W-1:0]      rd_sel,
   output logic [CNT_W-1:0]      rd_data,
   output logic                  rd_ovf,
   output logic                  frozen,
   output logic                  any_ovf,
   output perf_state_t           dbg_state
);

   localparam int NUM_CNT = NUM_EVENTS + 1;

   perf_state_t      r_state;
   perf_state_t      w_state_nxt;
   logic             w_count_en;
   logic [NUM_CNT-1:0] w_inc;
   logic [NUM_CNT-1:0] w_ovf;
   logic [CNT_W-1:0] w_cnt [NUM_CNT];
   logic [CNT_W-1:0] w_rd_data_nxt;
   logic             w_rd_ovf_nxt;
   logic [CNT_W-1:0] r_rd_data;
   logic             r_rd_ovf;

   always_ff @(posedge clk) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_nxt;
   end

   // Once frozen, only clr (or rst) brings the bank back to RUN
   always_comb begin
      w_state_nxt = r_state;
      if (clr)
         w_state_nxt = RUN;
      else if ((r_state == RUN) && halt)
         w_state_nxt = FROZEN;
   end

   // The halt cycle itself still counts: gating uses the current state only
   always_comb begin
      w_count_en = (r_state == RUN) && en && !clr;
      w_inc      = {evt, 1'b1} & {NUM_CNT{w_count_en}};
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      perf_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .inc (w_inc[g]),
         .cnt (w_cnt[g]),
         .ovf (w_ovf[g])
      );
   end

   // Unused select codes above NUM_EVENTS read back as zero
   always_comb begin
      w_rd_data_nxt = '0;
      w_rd_ovf_nxt  = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            w_rd_data_nxt = w_cnt[i];
            w_rd_ovf_nxt  = w_ovf[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_rd_data <= '0;
         r_rd_ovf  <= 1'b0;
      end else begin
         r_rd_data <= w_rd_data_nxt;
         r_rd_ovf  <= w_rd_ovf_nxt;
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_ovf    = r_rd_ovf;
   assign frozen    = (r_state == FROZEN);
   assign any_ovf   = |w_ovf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 32-bit saturating bank and two 4-bit banks
// (saturating and wrapping) share one stimulus stream and one reference model.
module tb_perf_counter_bank;
   import perf_pkg::*;

   localparam int NE = 5;
   localparam int SW = 3;

   // ---------------- clock / reset / stimulus signals ----------------
   logic          clk = 1'b0;
   logic          rst, en, clr, halt;
   logic [NE-1:0] evt;
   logic [SW-1:0] rd_sel;

   always #5 clk = ~clk;

   logic [31:0] d0_data;
   logic [3:0]  d1_data, d2_data;
   logic        d0_ovf, d1_ovf, d2_ovf;
   logic        d0_fz, d1_fz, d2_fz;
   logic        d0_any, d1_any, d2_any;
   perf_state_t d0_st, d1_st, d2_st;

   perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(32), .SATURATE(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
      .rd_sel(rd_sel), .rd_data(d0_data), .rd_ovf(d0_ovf), .frozen(d0_fz),
      .any_ovf(d0_any), .dbg_state(d0_st));

   perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
      .rd_sel(rd_sel), .rd_data(d1_data), .rd_ovf(d1_ovf), .frozen(d1_fz),
      .any_ovf(d1_any), .dbg_state(d1_st));

   perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
      .rd_sel(rd_sel), .rd_data(d2_data), .rd_ovf(d2_ovf), .frozen(d2_fz),
      .any_ovf(d2_any), .dbg_state(d2_st));

   // ---------------- scoreboard bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counters as plain integers; the per-bank width and saturate choice
   // decide what happens when an increment goes past 2^w - 1.
   longint unsigned m_cnt [3][NE+1];
   bit              m_ovf [3][NE+1];
   bit              m_frz;
   longint unsigned m_rd  [3];
   bit              m_rov [3];
   bit              m_live = 1'b0;
   int              m_w   [3] = '{32, 4, 4};
   bit              m_sat [3] = '{1'b1, 1'b1, 1'b0};
   logic [31:0]     exp_q [$];

   function automatic bit m_any(input int k);
      bit r = 1'b0;
      for (int c = 0; c <= NE; c++) r |= m_ovf[k][c];
      return r;
   endfunction

   always @(posedge clk) begin
      logic [NE:0]     hits;
      longint unsigned top;
      m_live = 1'b1;
      hits   = {evt, 1'b1};
      if (rst || clr) begin
         for (int k = 0; k < 3; k++) begin
            for (int c = 0; c <= NE; c++) begin
               m_cnt[k][c] = 0;
               m_ovf[k][c] = 1'b0;
            end
            m_rd[k]  = 0;
            m_rov[k] = 1'b0;
         end
         m_frz = 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_rd[k]  = (rd_sel <= NE) ? m_cnt[k][rd_sel] : 0;
            m_rov[k] = (rd_sel <= NE) ? m_ovf[k][rd_sel] : 1'b0;
         end
         if (!m_frz && en) begin
            for (int k = 0; k < 3; k++) begin
               top = (64'd1 << m_w[k]) - 64'd1;
               for (int c = 0; c <= NE; c++) begin
                  if (hits[c]) begin
                     if (m_cnt[k][c] == top) begin
                        m_ovf[k][c] = 1'b1;
                        m_cnt[k][c] = m_sat[k] ? top : 0;
                     end else begin
                        m_cnt[k][c] = m_cnt[k][c] + 1;
                     end
                  end
               end
            end
         end
         if (!m_frz && halt) m_frz = 1'b1;
      end
      exp_q.push_back(m_rd[0][31:0]);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_live) begin
         if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 64'd0, 64'd1);
         end else begin
            check("d0_rd_data", d0_data, exp_q.pop_front());
         end
         check("d0_rd_ovf",  d0_ovf,  m_rov[0]);
         check("d1_rd_data", d1_data, m_rd[1]);
         check("d1_rd_ovf",  d1_ovf,  m_rov[1]);
         check("d2_rd_data", d2_data, m_rd[2]);
         check("d2_rd_ovf",  d2_ovf,  m_rov[2]);
         check("d0_frozen",  d0_fz,   m_frz);
         check("d1_frozen",  d1_fz,   m_frz);
         check("d2_frozen",  d2_fz,   m_frz);
         check("d0_any_ovf", d0_any,  m_any(0));
         check("d1_any_ovf", d1_any,  m_any(1));
         check("d2_any_ovf", d2_any,  m_any(2));
         check("d0_state",   d0_st,   m_frz ? FROZEN : RUN);
      end
   end

   // ---------------- driver ----------------
   task automatic cyc(input bit r, input bit c, input bit e, input logic [NE-1:0] ev,
                      input bit h, input logic [SW-1:0] s);
      rst    = r;
      clr    = c;
      en     = e;
      evt    = ev;
      halt   = h;
      rd_sel = s;
      @(negedge clk);
   endtask

   initial begin
      longint unsigned v3;

      // reset
      cyc(1, 0, 0, '0, 0, '0);
      cyc(1, 0, 0, '0, 0, '0);
      check("rst_rd_data", d0_data, 64'd0);
      check("rst_frozen",  d0_fz,   64'd0);
      check("rst_any_ovf", d1_any,  64'd0);

      // basic counting: 10 enabled cycles, evt[0] on three of them
      for (int i = 0; i < 10; i++)
         cyc(0, 0, 1, (i == 2 || i == 5 || i == 8) ? NE'(1) : NE'(0), 0, SW'(1));
      check("basic_model_cycles", m_cnt[0][0], 64'd10);
      check("basic_model_evt0",   m_cnt[0][1], 64'd3);
      cyc(0, 0, 0, '0, 0, SW'(1));
      check("basic_rd_data", d0_data, 64'd3);

      // halt freeze: event on the halt cycle counts, nothing after it
      for (int i = 0; i < 9; i++)
         cyc(0, 0, 1, NE'($urandom), 0, SW'($urandom_range(0, 7)));
      v3 = m_cnt[0][3];
      cyc(0, 0, 1, NE'(5'b00100), 1, SW'(3));
      check("halt_frozen",    d0_fz,       64'd1);
      check("halt_evt_model", m_cnt[0][3], v3 + 1);
      for (int i = 0; i < 50; i++)
         cyc(0, 0, 1, NE'($urandom), 1'($urandom), SW'(3));
      check("halt_hold_rd", d0_data, v3 + 1);
      check("halt_still_frozen", d0_fz, 64'd1);

      // clear beats a simultaneous event while frozen
      cyc(0, 1, 1, NE'(1), 0, SW'(1));
      check("clr_frozen",  d0_fz,       64'd0);
      check("clr_rd_data", d0_data,     64'd0);
      check("clr_model",   m_cnt[0][1], 64'd0);
      cyc(0, 0, 1, NE'(1), 0, SW'(1));
      cyc(0, 0, 0, '0, 0, SW'(1));
      check("clr_next_evt", d0_data, 64'd1);

      // saturation and wrap on 4-bit banks: 17 evt[1] events
      cyc(0, 1, 0, '0, 0, '0);
      for (int i = 0; i < 17; i++)
         cyc(0, 0, 1, NE'(5'b00010), 0, SW'(2));
      cyc(0, 0, 0, '0, 0, SW'(2));
      check("sat_rd_data",  d1_data, 64'hF);
      check("sat_rd_ovf",   d1_ovf,  64'd1);
      check("sat_any_ovf",  d1_any,  64'd1);
      check("wrap_rd_data", d2_data, 64'd1);
      check("wrap_rd_ovf",  d2_ovf,  64'd1);
      check("wide_no_ovf",  d0_any,  64'd0);

      // reset mid-run
      for (int i = 0; i < 6; i++)
         cyc(0, 0, 1, NE'($urandom), 0, SW'(1));
      cyc(1, 0, 1, NE'($urandom), 0, SW'(1));
      check("midrst_rd_data", d0_data, 64'd0);
      check("midrst_any_ovf", d1_any,  64'd0);
      check("midrst_frozen",  d0_fz,   64'd0);

      // select codes beyond the last counter
      for (int i = 0; i < 20; i++)
         cyc(0, 0, 1, NE'(5'b11111), 0, SW'(0));
      cyc(0, 0, 0, '0, 0, SW'(NE + 1));
      check("badsel_rd_data", d1_data, 64'd0);
      check("badsel_rd_ovf",  d1_ovf,  64'd0);
      cyc(0, 0, 0, '0, 0, SW'(7));
      check("badsel7_rd_data", d0_data, 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
             $urandom_range(0, 7) != 0, NE'($urandom),
             $urandom_range(0, 99) == 0, SW'($urandom_range(0, 7)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
